// File: rtl/gf_inv_seq.sv
// gf_inv_seq: sequential GF(2^M) inverter.
// Computes a^-1 = a^(2^M-2) as the product a^2 * a^4 * ... * a^(2^(M-1)),
// taking one squaring and one multiplication per CALC cycle.
// Zero maps to zero naturally because every factor of the product is zero.
// Handshake: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
module gf_inv_seq #(
    parameter int         M    = 4,
    parameter logic [M:0] POLY = 5'h13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] din,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] dout,
    output logic         busy
);

    // Reject illegal field degrees and polynomials whose top coefficient is missing.
    generate
        if ((M < 2) || (M > 16)) begin : g_bad_m
            $error("gf_inv_seq: M must lie in 2..16");
        end
        if (POLY[M] != 1'b1) begin : g_bad_poly
            $error("gf_inv_seq: POLY[M] must be 1");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int               CW       = $clog2(M);
    localparam logic [CW-1:0]    CNT_LAST = CW'(M - 2);
    localparam logic [M-1:0]     ONE      = {{(M-1){1'b0}}, 1'b1};
    localparam logic [M-1:0]     ZERO     = {M{1'b0}};

    // Shift-and-add GF(2^M) multiply; each shift of the partial operand is reduced
    // immediately, so every intermediate value stays M bits wide.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] sh;
        logic         carry;
        acc = ZERO;
        sh  = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end else begin
                acc = acc;
            end
            carry = sh[M-1];
            sh    = sh << 1;
            if (carry) begin
                sh = sh ^ POLY[M-1:0];
            end else begin
                sh = sh;
            end
        end
        return acc;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [M-1:0]  sq_q, sq_d;
    logic [M-1:0]  res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [M-1:0]  sq_next_s;
    logic [M-1:0]  res_next_s;
    logic          accept_s;

    assign sq_next_s  = gf_mul(sq_q, sq_q);
    assign res_next_s = gf_mul(res_q, sq_next_s);

    assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready);
    assign accept_s  = in_valid & in_ready;
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_CALC);
    assign dout      = (state_q == ST_HOLD) ? res_q : ZERO;

    // Next-state and datapath update: load on accept, iterate in CALC, hold the result in HOLD.
    always_comb begin
        state_d = state_q;
        sq_d    = sq_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_CALC;
                    sq_d    = din;
                    res_d   = ONE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                sq_d  = sq_next_s;
                res_d = res_next_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_HOLD: begin
                if (accept_s) begin
                    // Result consumed and a new operand taken in the same cycle.
                    state_d = ST_CALC;
                    sq_d    = din;
                    res_d   = ONE;
                    cnt_d   = {CW{1'b0}};
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sq_d    = ZERO;
                res_d   = ZERO;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sq_q    <= ZERO;
            res_q   <= ZERO;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            sq_q    <= sq_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_gf_inv_seq.sv
// Scoreboard testbench for gf_inv_seq at M=4 (x^4+x+1) and M=8 (AES polynomial).
// Expected inverses come from a brute-force search over a carry-less multiply model.
module tb_gf_inv_seq;

    typedef struct {
        int val;
        int acc;
    } exp_t;

    logic clk;
    int   cyc;
    int   checks;
    int   failures;

    exp_t q_a[$];
    exp_t q_b[$];

    // instance A: M=4
    logic       rst_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
    logic [3:0] din_a, dout_a;
    // instance B: M=8
    logic       rst_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic [7:0] din_b, dout_b;

    gf_inv_seq #(.M(4), .POLY(5'h13)) dut_a (
        .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .din(din_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .dout(dout_a), .busy(busy_a)
    );

    gf_inv_seq #(.M(8), .POLY(9'h11B)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .din(din_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .dout(dout_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model: polynomial product reduced modulo poly
    function automatic int clmul_mod(input int a, input int b, input int m, input int poly);
        int p;
        p = 0;
        for (int i = 0; i < m; i++) begin
            if (((b >> i) & 1) == 1) p = p ^ (a << i);
        end
        for (int i = 2 * m - 2; i >= m; i--) begin
            if (((p >> i) & 1) == 1) p = p ^ (poly << (i - m));
        end
        return p;
    endfunction

    // reference inverse by exhaustive search; 0 maps to 0
    function automatic int ref_inv(input int a, input int m, input int poly);
        int r;
        r = 0;
        for (int b = 1; b < (1 << m); b++) begin
            if (clmul_mod(a, b, m, poly) == 1) r = b;
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic issue_a(input int v, input bit ordy, input int exp_v);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        in_valid_a  = 1'b1;
        din_a       = 4'(v);
        out_ready_a = ordy;
        #1;
        while (!in_ready_a && n < 200) begin
            @(negedge clk);
            out_ready_a = ordy ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            n++;
        end
        if (!in_ready_a) begin
            chk("a_accept_timeout", 0, 1);
        end else begin
            e.val = (exp_v >= 0) ? exp_v : ref_inv(v, 4, 'h13);
            e.acc = cyc + 1;
            q_a.push_back(e);
        end
        @(negedge clk);
        in_valid_a = 1'b0;
        din_a      = 4'($urandom);
    endtask

    task automatic issue_b(input int v, input int exp_v);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        in_valid_b = 1'b1;
        din_b      = 8'(v);
        #1;
        while (!in_ready_b && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready_b) begin
            chk("b_accept_timeout", 0, 1);
        end else begin
            e.val = (exp_v >= 0) ? exp_v : ref_inv(v, 8, 'h11B);
            e.acc = cyc + 1;
            q_b.push_back(e);
        end
        @(negedge clk);
        in_valid_b = 1'b0;
        din_b      = 8'($urandom);
    endtask

    // monitor A: result values, latency, hold stability, idle zero, ready rule
    initial begin
        logic       prev_v;
        logic       prev_take;
        logic [3:0] prev_d;
        exp_t       e;
        prev_v    = 1'b0;
        prev_take = 1'b0;
        prev_d    = 4'd0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_a) begin
                chk("a_in_ready_rule", int'(in_ready_a),
                    int'(!busy_a && (!out_valid_a || out_ready_a)));
                chk("a_busy_ov_excl", int'(busy_a & out_valid_a), 0);
                if (out_valid_a) begin
                    if (!prev_v || prev_take) begin
                        if (q_a.size() == 0) begin
                            chk("a_spurious_result", 1, 0);
                        end else begin
                            e = q_a[0];
                            chk("a_dout", int'(dout_a), e.val);
                            chk("a_latency", cyc - e.acc, 3);
                        end
                    end else begin
                        chk("a_hold_stable", int'(dout_a), int'(prev_d));
                    end
                    if (out_ready_a && q_a.size() > 0) void'(q_a.pop_front());
                end else begin
                    chk("a_dout_zero_idle", int'(dout_a), 0);
                end
            end
            prev_v    = out_valid_a && !rst_a;
            prev_take = out_valid_a && out_ready_a;
            prev_d    = dout_a;
        end
    end

    // monitor B: consumer always ready, so every valid cycle is a fresh result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_b) begin
                if (out_valid_b) begin
                    if (q_b.size() == 0) begin
                        chk("b_spurious_result", 1, 0);
                    end else begin
                        e = q_b.pop_front();
                        chk("b_dout", int'(dout_b), e.val);
                        chk("b_latency", cyc - e.acc, 7);
                    end
                end else begin
                    chk("b_dout_zero_idle", int'(dout_b), 0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        checks      = 0;
        failures    = 0;
        rst_a       = 1'b1;
        rst_b       = 1'b1;
        in_valid_a  = 1'b0;
        in_valid_b  = 1'b0;
        din_a       = 4'd0;
        din_b       = 8'd0;
        out_ready_a = 1'b1;
        out_ready_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready_a), 1);
        chk("rst_out_valid", int'(out_valid_a), 0);
        chk("rst_dout", int'(dout_a), 0);
        chk("rst_busy", int'(busy_a), 0);

        // basic example and small values, back-to-back
        issue_a(2, 1'b1, 9);
        issue_a(0, 1'b1, 0);
        issue_a(1, 1'b1, 1);
        issue_a(3, 1'b1, 14);
        // exhaustive sweep
        for (int v = 0; v < 16; v++) issue_a(v, 1'b1, -1);

        // backpressure in HOLD, then simultaneous consume + accept
        issue_a(7, 1'b0, -1);
        repeat (8) @(negedge clk);
        issue_a(11, 1'b1, -1);

        // input noise while computing must be ignored
        issue_a(6, 1'b1, -1);
        repeat (2) begin
            @(negedge clk);
            in_valid_a = 1'($urandom_range(0, 1));
            din_a      = 4'($urandom);
        end
        @(negedge clk);
        in_valid_a = 1'b0;
        repeat (3) @(negedge clk);

        // reset in the second CALC cycle discards the operand
        issue_a(2, 1'b1, 9);
        @(negedge clk);
        rst_a = 1'b1;
        q_a.delete();
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy_a), 0);
        chk("mid_rst_out_valid", int'(out_valid_a), 0);
        repeat (6) @(negedge clk);
        issue_a(2, 1'b1, 9);
        repeat (6) @(negedge clk);

        // reset wins over a simultaneous accept
        @(negedge clk);
        rst_a      = 1'b1;
        in_valid_a = 1'b1;
        din_a      = 4'd4;
        @(negedge clk);
        rst_a      = 1'b0;
        in_valid_a = 1'b0;
        #1;
        chk("rst_accept_busy", int'(busy_a), 0);
        repeat (6) @(negedge clk);

        // randomized traffic with random backpressure
        for (int i = 0; i < 40; i++) issue_a(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), -1);
        @(negedge clk);
        out_ready_a = 1'b1;
        n = 0;
        while (q_a.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("a_drain", q_a.size(), 0);

        // M=8: AES example then exhaustive sweep
        issue_b('h53, 'hCA);
        for (int v = 0; v < 256; v++) issue_b(v, -1);
        n = 0;
        while (q_b.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b_drain", q_b.size(), 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gf_inv_seq.md
GF_INV_SEQ -- requirements
Module: gf_inv_seq

Interface
REQ-001 The block SHALL have parameter M, default 4: field degree, legal range 2..16.
REQ-002 The block SHALL have parameter POLY, default 'h13: reduction polynomial, M+1 bits, bit M set (default x^4+x+1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: din holds an operand.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand this cycle.
REQ-007 The block SHALL have port din, input, M bits: field element a, polynomial basis, bit 0 = x^0.
REQ-008 The block SHALL have port out_valid, output, 1 bit: dout holds a result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-010 The block SHALL have port dout, output, M bits: a^-1 in GF(2^M) mod POLY, with 0 mapped to 0.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in state CALC.

Function
REQ-012 The block SHALL compute dout = a^(2^M-2) by iterative square-and-multiply:
- on accept: sq<=a, res<=1, cnt<=0;
- each CALC cycle: sq<=sq^2 mod POLY, res<=res*(sq^2) mod POLY, cnt<=cnt+1.
REQ-013 Squaring and multiplication SHALL be single-cycle combinational GF(2^M) operations reduced modulo POLY; the operands SHALL be exactly M bits wide, with no carries.
REQ-014 The FSM SHALL have states IDLE, CALC and HOLD.
REQ-015 IDLE->CALC SHALL occur on an accept (in_valid & in_ready); otherwise the FSM SHALL remain in IDLE.
REQ-016 CALC SHALL last exactly M-1 cycles; on the edge where cnt reaches M-2 it SHALL transition to HOLD.
REQ-017 HOLD->IDLE SHALL occur when out_ready=1 and in_valid=0; HOLD->CALC SHALL occur when out_ready=1 and in_valid=1, which is a simultaneous accept; otherwise the FSM SHALL remain in HOLD.
REQ-018 in_ready SHALL equal (state==IDLE) | (state==HOLD & out_ready); it SHALL be 0 throughout CALC, and an in_valid asserted during CALC SHALL be ignored.
REQ-019 out_valid SHALL be 1 exactly in HOLD; dout SHALL equal res in HOLD and SHALL stay stable until out_ready is sampled high.
REQ-020 Latency SHALL be M-1 cycles from the accept edge to the first cycle of out_valid=1 (3 cycles at M=4); sustained throughput SHALL be one result per M cycles.
REQ-021 din SHALL be sampled only on the accept edge; later changes to din SHALL not affect the result.
REQ-022 a=0 SHALL yield dout=0 and a=1 SHALL yield dout=1, with no special-case path: both SHALL fall out of the exponentiation.
REQ-023 dout SHALL be 0 whenever out_valid=0.
REQ-024 An elaboration-time check SHALL fail if M<2, M>16, or POLY[M]!=1.

Reset
REQ-025 On a clk edge with rst=1: state SHALL become IDLE; sq, res and cnt SHALL be cleared; out_valid, dout and busy SHALL be 0; in_ready SHALL be 1 in the first cycle after reset.
REQ-026 rst SHALL take priority over every other input, including a simultaneous accept.
REQ-027 rst asserted mid-CALC or in HOLD SHALL discard the operand, with no result ever presented.

Verification
REQ-028 M=4, POLY='h13, out_ready=1: din=2 accepted -> out_valid rises 3 cycles later with dout=9, held one cycle, then in_ready=1.
REQ-029 M=4: din=0, 1, 3 in sequence -> dout=0, 1, 'hE respectively; an exhaustive sweep of all 16 inputs SHALL give a*dout=1 for every a!=0.
REQ-030 M=8, POLY='h11B: din='h53 -> dout='hCA after 7 cycles; an exhaustive sweep of all 256 values SHALL match a reference inverse table.
REQ-031 Backpressure: out_ready=0 for 5 cycles in HOLD -> dout and out_valid stay stable and in_ready=0; then out_ready=1 with in_valid=1 -> new operand accepted in the same cycle, and the next result appears M-1 cycles later.
REQ-032 rst pulsed at the 2nd CALC cycle -> busy=0 and out_valid=0 on the next cycle, no stale result appears, and a following din=2 still yields 9.
REQ-033 in_valid toggling and din changing during CALC -> result unaffected, and no extra accept occurs.
